// File: rtl/caesar_decryptor_if.sv
// Message bus for the Caesar decryptor: key strobe plus cipher byte in,
// decrypted letter stream and full plaintext out.
interface caesar_decryptor_if #(
    parameter int unsigned N_LETTERS = 6
);
    localparam int unsigned FLAT_W = 5 * N_LETTERS;

    logic              go;
    logic [7:0]        data_in;
    logic [4:0]        out_letter;
    logic [2:0]        out_index;
    logic              out_valid;
    logic [FLAT_W-1:0] plain_flat;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output go, data_in,
        input  out_letter, out_index, out_valid, plain_flat, busy, done, err
    );

    modport slave (
        input  go, data_in,
        output out_letter, out_index, out_valid, plain_flat, busy, done, err
    );
endinterface

// File: rtl/caesar_decryptor.sv
// Caesar decryptor: loads N_LETTERS cipher letters on go edges, then streams
// one shifted-back letter per cycle and holds the plaintext until the next go.
module caesar_decryptor #(
    parameter int unsigned N_LETTERS = 6
) (
    input  logic                clk,
    input  logic                resetn,
    caesar_decryptor_if.slave   bus
);
    localparam int unsigned LAST   = N_LETTERS - 1;
    localparam int unsigned FLAT_W = 5 * N_LETTERS;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        DECRYPT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [1:0]        shift;
    logic              go_d;
    logic              go_armed;
    logic [FLAT_W-1:0] buffer_flat;

    logic              go_edge;
    logic [1:0]        din_shift;
    logic              din_bad_shift;
    logic [4:0]        din_code;
    logic [2:0]        emit_idx;
    logic [4:0]        emit_code;
    logic [1:0]        emit_shift;
    logic [4:0]        emit_letter;
    logic              emit_bad;
    logic              unused_bit;

    assign unused_bit = bus.data_in[5];

    // Letters above Z pass through untouched; others wrap modulo 26.
    function automatic logic [4:0] dec(input logic [4:0] c, input logic [1:0] s);
        logic [5:0] w;
        w = 6'd0;
        if (c > 5'd25) begin
            return c;
        end
        if (c >= 5'(s)) begin
            w = 6'(c) - 6'(s);
        end else begin
            w = 6'(c) + 6'd26 - 6'(s);
        end
        return w[4:0];
    endfunction

    // Edge detect gated by go_armed so a go held through reset is not an edge.
    always_comb begin
        go_edge       = bus.go & ~go_d & go_armed;
        din_code      = bus.data_in[4:0];
        din_bad_shift = (bus.data_in[7:6] == 2'd3);
        din_shift     = din_bad_shift ? 2'd0 : bus.data_in[7:6];
        emit_idx      = 3'd0;
        emit_code     = buffer_flat[4:0];
        emit_shift    = shift;
        if (state == DECRYPT) begin
            emit_idx  = (cnt == 3'(LAST)) ? 3'd0 : cnt + 3'd1;
            emit_code = buffer_flat[5*emit_idx +: 5];
        end else if (LAST == 0) begin
            // Single-letter message: the letter and key arrive on the same edge.
            emit_code  = din_code;
            emit_shift = din_shift;
        end
        emit_letter = dec(emit_code, emit_shift);
        emit_bad    = (emit_code > 5'd25);
    end

    // Outputs for letter cnt are registered on the edge that selects cnt,
    // so out_valid coincides with the DECRYPT state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= LOAD;
            cnt            <= 3'd0;
            shift          <= 2'd0;
            go_d           <= 1'b0;
            go_armed       <= 1'b0;
            buffer_flat    <= '0;
            bus.plain_flat <= '0;
            bus.out_letter <= 5'd0;
            bus.out_index  <= 3'd0;
            bus.out_valid  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            go_d <= bus.go;
            if (!bus.go) begin
                go_armed <= 1'b1;
            end
            case (state)
                LOAD: begin
                    if (go_edge) begin
                        buffer_flat[5*cnt +: 5] <= din_code;
                        if (cnt == 3'd0) begin
                            shift <= din_shift;
                            if (din_bad_shift) begin
                                bus.err <= 1'b1;
                            end
                        end
                        if (cnt == 3'(LAST)) begin
                            state               <= DECRYPT;
                            cnt                 <= 3'd0;
                            bus.busy            <= 1'b1;
                            bus.out_valid       <= 1'b1;
                            bus.out_index       <= 3'd0;
                            bus.out_letter      <= emit_letter;
                            bus.plain_flat[4:0] <= emit_letter;
                            if (emit_bad) begin
                                bus.err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                DECRYPT: begin
                    if (cnt == 3'(LAST)) begin
                        state          <= DONE;
                        cnt            <= 3'd0;
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
                        bus.out_valid  <= 1'b0;
                        bus.out_index  <= 3'd0;
                        bus.out_letter <= 5'd0;
                    end else begin
                        cnt                             <= emit_idx;
                        bus.out_index                   <= emit_idx;
                        bus.out_letter                  <= emit_letter;
                        bus.plain_flat[5*emit_idx +: 5] <= emit_letter;
                        if (emit_bad) begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (go_edge) begin
                        state          <= LOAD;
                        cnt            <= 3'd0;
                        bus.err        <= 1'b0;
                        bus.done       <= 1'b0;
                        bus.plain_flat <= '0;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end
endmodule

// File: doc/caesar_decryptor.md
CAESAR_DECRYPTOR -- requirements
Module: caesar_decryptor

Interface
REQ-001 Parameter: N_LETTERS, default 6, number of cipher letters per message; legal range 1..8.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  reset, synchronous, active-low; clock clk.
REQ-004 go  input  1  level strobe from a debounced key; a letter is taken on its rising edge only.
REQ-005 data_in  input  8  [7:6] = shift key (0,1,2); [5] ignored; [4:0] = cipher letter code (A=0 .. Z=25).
REQ-006 out_letter  output  5  decrypted letter code, valid while out_valid=1.
REQ-007 out_index  output  3  position (0..N_LETTERS-1) of out_letter.
REQ-008 out_valid  output  1  one-cycle pulse per decrypted letter.
REQ-009 plain_flat  output  5*N_LETTERS  all decrypted letters; letter i in bits [5i+4:5i]; stable in DONE.
REQ-010 busy  output  1  high in DECRYPT.
REQ-011 done  output  1  high in DONE.
REQ-012 err  output  1  sticky error flag for the current message.

Function
REQ-013 Rising edge of go: go=1 this cycle and go=0 the previous cycle (internal go_d register); go high across many cycles is one edge.
REQ-014 States: LOAD, DECRYPT, DONE; 2-bit encoding.
REQ-015 LOAD: on each go edge, data_in[4:0] goes to buffer[cnt] and cnt increments; with no edge, nothing changes.
REQ-016 On the go edge with cnt=0, shift register <= data_in[7:6]; shift bits on later letters are ignored.
REQ-017 Shift key 3: err <= 1 and the shift register is stored as 0.
REQ-018 The go edge that loads letter N_LETTERS-1 moves LOAD->DECRYPT on the next clock; cnt <= 0.
REQ-019 DECRYPT: one letter per cycle, index cnt = 0..N_LETTERS-1; out_valid=1, out_index=cnt, out_letter=dec(buffer[cnt]) in that cycle.
REQ-020 The decrypted letter is also written to plain_flat slot cnt in the same cycle.
REQ-021 dec(c) = c - shift if c >= shift, otherwise c + 26 - shift; result is always 0..25 for c in 0..25 (mod-26 wrap-around).
REQ-022 Letter code c > 25: out_letter = c unchanged and err <= 1.
REQ-023 After the cycle with cnt = N_LETTERS-1, DECRYPT->DONE.
REQ-024 Latency: the last load edge is sampled at cycle T; out_valid is high in cycles T+1..T+N_LETTERS; done is high from T+N_LETTERS+1.
REQ-025 go edges during DECRYPT are ignored; they do not load letters and are not queued.
REQ-026 DONE: done=1 and plain_flat holds; the state persists indefinitely.
REQ-027 A go edge in DONE clears cnt, err, done and plain_flat, and returns the FSM to LOAD; that edge loads no letter.
REQ-028 out_valid=0 and out_letter/out_index=0 outside DECRYPT.
REQ-029 busy=1 exactly in DECRYPT; done=1 exactly in DONE.

Reset
REQ-030 resetn=0 at a rising edge: state=LOAD, cnt=0, shift=0, go_d=0, buffer and plain_flat all 0, and every output 0.
REQ-031 Reset applies in any state, including mid-LOAD and mid-DECRYPT; a partial message is discarded with no further out_valid pulses.
REQ-032 A go held high through reset release yields no edge until go has been seen low.

Verification
REQ-033 Shift 1; letters 1,2,3,4,5,0 -> out_letter 0,1,2,3,4,25 at indices 0..5 on 6 consecutive cycles; done one cycle after index 5; plain_flat = {25,4,3,2,1,0}.
REQ-034 Shift 2; letters 0,1,2,25,13,7 -> 24,25,0,23,11,5; err=0.
REQ-035 go held high 10 cycles, then low, then one more edge -> exactly 2 letters loaded (cnt=2), state LOAD.
REQ-036 Shift 3 on the first letter, or a letter code 30 -> err=1 through DONE; the code-30 letter outputs 30; a go edge in DONE clears err.
REQ-037 resetn=0 for 1 cycle after the 3rd out_valid in DECRYPT -> state LOAD, out_valid=0, done=0, plain_flat=0; a new 6-letter message then decrypts correctly.
REQ-038 go edges during DECRYPT -> output sequence unchanged; a message after DONE->LOAD begins at index 0.
